// File: rtl/mem_if_pkg.sv
// Purpose: shared memory-interface constants and the line-mover state enum.
// Used by the line mover and by the cache controller that drives it.
package mem_if_pkg;

   localparam int unsigned MEM_ADDR_LEN      = 11;
   localparam int unsigned MEM_LINE_ADDR_LEN = 3;
   localparam int unsigned MEM_LINE_WORDS    = 1 << MEM_LINE_ADDR_LEN;
   localparam int unsigned MEM_DATA_LEN      = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } mem_state_e;

endpackage

// File: rtl/mem_line_mover_if.sv
// Purpose: request, cache line-buffer and memory bus of the line mover.
// Ports (signals):
//   req/req_we/req_line          transfer request from cache controller
//   busy/done                    transfer status
//   ld_valid/ld_idx/ld_data      refill words into the cache line buffer
//   st_idx/st_data               writeback word fetch from the cache
//   mem_addr/mem_wr_req/mem_wr_data/mem_rd_data  word memory port
// Modports: master = line mover, slave = controller/cache/memory side.
interface mem_line_mover_if
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_LEN      = MEM_ADDR_LEN,
   parameter int unsigned LINE_ADDR_LEN = MEM_LINE_ADDR_LEN
) ();

   localparam int unsigned LINE_LEN = ADDR_LEN - LINE_ADDR_LEN;

   logic                     req;
   logic                     req_we;
   logic [LINE_LEN-1:0]      req_line;
   logic                     busy;
   logic                     done;
   logic                     ld_valid;
   logic [LINE_ADDR_LEN-1:0] ld_idx;
   logic [MEM_DATA_LEN-1:0]  ld_data;
   logic [LINE_ADDR_LEN-1:0] st_idx;
   logic [MEM_DATA_LEN-1:0]  st_data;
   logic [ADDR_LEN-1:0]      mem_addr;
   logic                     mem_wr_req;
   logic [MEM_DATA_LEN-1:0]  mem_wr_data;
   logic [MEM_DATA_LEN-1:0]  mem_rd_data;

   modport master (
      input  req, req_we, req_line, st_data, mem_rd_data,
      output busy, done, ld_valid, ld_idx, ld_data, st_idx,
             mem_addr, mem_wr_req, mem_wr_data
   );

   modport slave (
      output req, req_we, req_line, st_data, mem_rd_data,
      input  busy, done, ld_valid, ld_idx, ld_data, st_idx,
             mem_addr, mem_wr_req, mem_wr_data
   );

endinterface

// File: rtl/mem_line_mover.sv
// Purpose: moves one cache line between the cache and a single-port word
// memory with 1-cycle registered read latency. Refill streams LINE_WORDS
// words memory->cache; writeback streams LINE_WORDS words cache->memory.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (aborts any transfer)
//   bus   mem_line_mover_if.master: request, line buffer and memory port
module mem_line_mover
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_LEN      = MEM_ADDR_LEN,
   parameter int unsigned LINE_ADDR_LEN = MEM_LINE_ADDR_LEN
) (
   input logic               clk,
   input logic               rst,
   mem_line_mover_if.master  bus
);

   localparam int unsigned LINE_LEN = ADDR_LEN - LINE_ADDR_LEN;
   localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;

   mem_state_e               state, state_nxt;
   logic [LINE_ADDR_LEN-1:0] cnt, cnt_nxt;
   logic                     pend, pend_nxt;
   logic [LINE_ADDR_LEN-1:0] pend_idx, pend_idx_nxt;
   logic [LINE_LEN-1:0]      line, line_nxt;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend     <= 1'b0;
         pend_idx <= '0;
         line     <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pend     <= pend_nxt;
         pend_idx <= pend_idx_nxt;
         line     <= line_nxt;
      end
   end

   // Next-state and output decode; direction is carried by the state itself
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pend_nxt     = pend;
      pend_idx_nxt = pend_idx;
      line_nxt     = line;

      bus.busy        = (state != IDLE);
      bus.done        = 1'b0;
      bus.ld_valid    = pend;
      bus.ld_idx      = pend_idx;
      bus.ld_data     = bus.mem_rd_data;
      bus.st_idx      = '0;
      bus.mem_addr    = '0;
      bus.mem_wr_req  = 1'b0;
      bus.mem_wr_data = '0;

      case (state)
         IDLE: begin
            if (bus.req) begin
               line_nxt  = bus.req_line;
               cnt_nxt   = '0;
               state_nxt = bus.req_we ? WRITE : READ;
            end
         end
         READ: begin
            // Word cnt returns from memory next cycle, tagged via pend_idx
            bus.mem_addr = {line, cnt};
            cnt_nxt      = LINE_ADDR_LEN'(cnt + 1'b1);
            pend_nxt     = 1'b1;
            pend_idx_nxt = cnt;
            if (cnt == CNT_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Last read word is on ld_data this cycle
            pend_nxt  = 1'b0;
            state_nxt = DONE;
         end
         WRITE: begin
            bus.mem_addr    = {line, cnt};
            bus.st_idx      = cnt;
            bus.mem_wr_data = bus.st_data;
            bus.mem_wr_req  = 1'b1;
            cnt_nxt         = LINE_ADDR_LEN'(cnt + 1'b1);
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_line_mover.sv
// Purpose: self-checking bench for mem_line_mover with a preloaded word
// memory, a cache line buffer model and a transaction-level shadow memory.
module tb_mem_line_mover;

   localparam int unsigned ADDR_LEN      = 11;
   localparam int unsigned LINE_ADDR_LEN = 3;
   localparam int unsigned LINE_WORDS    = 8;
   localparam int unsigned MEM_WORDS     = 2048;

   typedef struct {
      logic       we;
      logic [7:0] line;
      bit         seq_data;
      bit         keep;
      bit         scramble;
      int         exp_busy;
      int         exp_words;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic [31:0] st_buf  [LINE_WORDS];

   int n_cmp = 0;
   int n_bad = 0;

   mem_line_mover_if #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LINE_ADDR_LEN)) bus ();

   mem_line_mover #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LINE_ADDR_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      case (i)
         0: return 32'h2b;
         1: return 32'hc7;
         2: return 32'h69;
         3: return 32'hd4;
         4: return 32'h67;
         5: return 32'ha0;
         6: return 32'h8d;
         7: return 32'ha3;
         default: return (32'(i) * 32'h0001_0003) ^ 32'h5a5a_0000;
      endcase
   endfunction

   // Word memory: registered read, write on strobe
   initial for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);

   always @(posedge clk) begin
      if (bus.mem_wr_req) mem[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= mem[bus.mem_addr];
   end

   // Cache line buffer answers the writeback index combinationally
   assign bus.st_data = st_buf[bus.st_idx];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One transfer, started at a negedge with the mover idle; ends at the
   // negedge of the IDLE cycle following done.
   task automatic do_xfer(input logic we, input logic [7:0] line, input bit seq_data,
                          input bit keep, input bit scramble, input int exp_busy,
                          input int exp_words, input string tag);
      logic [10:0] base;
      int busy_n, ld_n, wr_n;
      bit got_done, first_busy;
      base = {line, 3'b000};
      for (int i = 0; i < LINE_WORDS; i++)
         st_buf[i] = seq_data ? 32'(100 + i) : $urandom;
      busy_n = 0; ld_n = 0; wr_n = 0; got_done = 0; first_busy = 0;
      bus.req = 1'b1;
      bus.req_we = we;
      bus.req_line = line;
      for (int c = 0; c < 40 && !got_done; c++) begin
         @(negedge clk);
         if (!keep) bus.req = 1'b0;
         if (c == 0) first_busy = bus.busy;
         if (bus.busy) busy_n++;
         if (bus.ld_valid) begin
            if (ld_n < LINE_WORDS) begin
               check($sformatf("%s ld_idx[%0d]", tag, ld_n), 64'(bus.ld_idx), 64'(ld_n));
               check($sformatf("%s ld_data[%0d]", tag, ld_n), 64'(bus.ld_data),
                     64'(ref_mem[11'(base + 11'(ld_n))]));
            end
            ld_n++;
         end
         if (bus.mem_wr_req) begin
            if (wr_n < LINE_WORDS) begin
               check($sformatf("%s wr_addr[%0d]", tag, wr_n), 64'(bus.mem_addr),
                     64'(base + 11'(wr_n)));
               check($sformatf("%s wr_data[%0d]", tag, wr_n), 64'(bus.mem_wr_data),
                     64'(st_buf[wr_n]));
            end
            wr_n++;
         end
         if (bus.done) got_done = 1;
         if (scramble) begin
            bus.req_we   = 1'($urandom);
            bus.req_line = 8'($urandom);
         end
      end
      check({tag, " done_seen"}, 64'(got_done), 64'd1);
      check({tag, " first_busy"}, 64'(first_busy), 64'd1);
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
      check({tag, " ld_count"}, 64'(ld_n), we ? 64'd0 : 64'(exp_words));
      check({tag, " wr_count"}, 64'(wr_n), we ? 64'(exp_words) : 64'd0);
      if (we)
         for (int i = 0; i < LINE_WORDS; i++) ref_mem[11'(base + 11'(i))] = st_buf[i];
      @(negedge clk);
      check({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
      check({tag, " idle_done"}, 64'(bus.done), 64'd0);
      check({tag, " idle_ld_valid"}, 64'(bus.ld_valid), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      logic [10:0] base;
      bit seen;
      int done_n, busy_n;

      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < LINE_WORDS; i++) st_buf[i] = '0;
      rst = 1'b1;
      bus.req = 1'b0;
      bus.req_we = 1'b0;
      bus.req_line = '0;

      // Reset state
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst done", 64'(bus.done), 64'd0);
      check("rst ld_valid", 64'(bus.ld_valid), 64'd0);
      check("rst mem_wr_req", 64'(bus.mem_wr_req), 64'd0);
      check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst st_idx", 64'(bus.st_idx), 64'd0);
      check("rst mem_wr_data", 64'(bus.mem_wr_data), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      //                we    line    seq keep scr busy words
      vecs.push_back('{1'b0, 8'd0,   0,  0,  0,  10,  8});
      vecs.push_back('{1'b1, 8'd5,   1,  0,  0,   9,  8});
      vecs.push_back('{1'b0, 8'd5,   0,  0,  0,  10,  8});
      vecs.push_back('{1'b0, 8'd255, 0,  0,  0,  10,  8});
      vecs.push_back('{1'b1, 8'd255, 0,  0,  0,   9,  8});
      vecs.push_back('{1'b0, 8'd255, 0,  0,  0,  10,  8});
      vecs.push_back('{1'b0, 8'd9,   0,  0,  1,  10,  8});
      vecs.push_back('{1'b1, 8'd9,   0,  0,  1,   9,  8});
      vecs.push_back('{1'b0, 8'd9,   0,  0,  0,  10,  8});
      vecs.push_back('{1'b1, 8'd20,  0,  1,  0,   9,  8});
      vecs.push_back('{1'b0, 8'd20,  0,  1,  1,  10,  8});
      vecs.push_back('{1'b1, 8'd21,  0,  1,  0,   9,  8});
      vecs.push_back('{1'b0, 8'd21,  0,  0,  0,  10,  8});
      foreach (vecs[v])
         do_xfer(vecs[v].we, vecs[v].line, vecs[v].seq_data, vecs[v].keep,
                 vecs[v].scramble, vecs[v].exp_busy, vecs[v].exp_words,
                 $sformatf("vec%0d", v));

      // Reset while the writeback is presenting word 3
      base = {8'd77, 3'b000};
      for (int i = 0; i < LINE_WORDS; i++) st_buf[i] = $urandom;
      bus.req = 1'b1;
      bus.req_we = 1'b1;
      bus.req_line = 8'd77;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         bus.req = 1'b0;
         if (bus.mem_wr_req && bus.mem_addr == 11'(base + 11'd3)) begin
            seen = 1;
            rst = 1'b1;
            #1;
            check("abort mem_wr_req", 64'(bus.mem_wr_req), 64'd0);
            check("abort busy", 64'(bus.busy), 64'd0);
            check("abort mem_addr", 64'(bus.mem_addr), 64'd0);
         end
      end
      check("abort trigger_seen", 64'(seen), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      done_n = 0;
      busy_n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.done) done_n++;
         if (bus.busy) busy_n++;
      end
      check("abort done_pulses", 64'(done_n), 64'd0);
      check("abort busy_after", 64'(busy_n), 64'd0);
      for (int i = 0; i < 3; i++) ref_mem[11'(base + 11'(i))] = st_buf[i];
      do_xfer(1'b0, 8'd77, 0, 0, 0, 10, 8, "abort_readback");

      // Random transfers against the shadow memory
      for (int r = 0; r < 24; r++) begin
         logic we_r;
         bit keep_r;
         we_r   = 1'($urandom);
         keep_r = (r == 23) ? 1'b0 : 1'($urandom);
         do_xfer(we_r, 8'($urandom_range(0, 255)), 0, keep_r, 1'($urandom),
                 we_r ? LINE_WORDS + 1 : LINE_WORDS + 2, LINE_WORDS,
                 $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
